// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath.
// master: sequencer side (drives selects/enables/status, samples opcode/flags).
// slave : datapath side (drives opcode, zero flag and memory ready).
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  // datapath -> sequencer
  logic [5:0]       i_opcode;       // IR[31:26]
  logic             i_zero;         // ALU zero flag, consumed by the datapath
  logic             i_mem_ready;    // memory completes the access this cycle

  // sequencer -> datapath
  logic             o_pcWrite;      // unconditional PC load
  logic             o_pcWriteCond;  // PC load when zero
  logic             o_iorD;         // 0=PC addresses memory, 1=ALUOut
  logic             o_memRead;      // memory read strobe
  logic             o_memWrite;     // memory write strobe
  logic             o_irWrite;      // IR load
  logic             o_memToReg;     // 0=ALUOut, 1=MDR to regfile
  logic             o_regDst;       // 0=rt, 1=rd
  logic             o_regWrite;     // regfile write enable
  logic             o_aluSrcA;      // 0=PC, 1=A
  logic [1:0]       o_aluSrcB;      // 00=B, 01=4, 10=signext, 11=signext<<2
  logic [1:0]       o_aluOp;        // 00 add, 01 sub, 10 funct-decoded
  logic             o_aluConI;      // ALU control decodes opcode instead of funct
  logic [1:0]       o_pcSrc;        // 00=ALU, 01=ALUOut, 10=jump target

  // status / debug
  logic [3:0]       o_state;        // current state encoding
  logic [CNT_W-1:0] o_retired;      // retired-instruction count, wraps
  logic             o_illegal;      // one-cycle pulse on unknown opcode
  logic             o_fault;        // sticky memory-timeout flag

  modport master (
    input  i_opcode, i_zero, i_mem_ready,
    output o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp,
           o_aluConI, o_pcSrc, o_state, o_retired, o_illegal, o_fault
  );

  modport slave (
    output i_opcode, i_zero, i_mem_ready,
    input  o_pcWrite, o_pcWriteCond, o_iorD, o_memRead, o_memWrite, o_irWrite,
           o_memToReg, o_regDst, o_regWrite, o_aluSrcA, o_aluSrcB, o_aluOp,
           o_aluConI, o_pcSrc, o_state, o_retired, o_illegal, o_fault
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS sequencer: Moore FSM driving all datapath selects/enables, one micro-step per clock.
// Latency: beq/j 3 cycles, R-type/I-ALU/sw 4, lw 5, plus one per memory not-ready cycle.
// Backpressure: i_mem_ready stalls FETCH/MEMRD/MEMWR; more than MEM_WAIT_MAX consecutive stalls -> FAULT.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-high reset (returns to FETCH, clears counters/fault)
//   bus    - mc_ctrl_if.master: opcode/zero/mem_ready in; datapath controls,
//            o_state, o_retired, o_illegal, o_fault out
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15,  // tolerated consecutive not-ready cycles (>=1)
  parameter int CNT_W        = 32   // retired counter width
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mc_ctrl_if.master bus
);

  localparam int WCNT_W = $clog2(MEM_WAIT_MAX + 1);

  // State encoding (visible on o_state for debug)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_IEXEC  = 4'd8;
  localparam logic [3:0] S_IWB    = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  logic [3:0]        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_retired;

  logic [3:0] w_next;
  logic       w_retire;
  logic       w_illegal;
  logic       w_mem_state;
  logic       w_wait_expired;

  // ---------------------------------------------------------------------------
  // Wait-state supervision: only states that own the memory port can stall.
  // The counter holds the number of not-ready cycles already spent in this
  // state, so a not-ready cycle seen with the counter at MEM_WAIT_MAX is the
  // (MEM_WAIT_MAX+1)th one and trips FAULT. A ready on that same cycle wins.
  // ---------------------------------------------------------------------------
  assign w_mem_state    = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                          (r_state == S_MEMWR);
  assign w_wait_expired = w_mem_state && !bus.i_mem_ready &&
                          (r_wait_cnt == WCNT_W'(MEM_WAIT_MAX));

  // ---------------------------------------------------------------------------
  // Next-state, retire and illegal-opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (bus.i_mem_ready)     w_next = S_DECODE;
        else if (w_wait_expired) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (bus.i_opcode)
          OP_RTYPE:                        w_next = S_EXEC;
          OP_LW, OP_SW:                    w_next = S_MEMADR;
          OP_BEQ:                          w_next = S_BRANCH;
          OP_J:                            w_next = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_next = S_IEXEC;
          default: begin
            // Unknown opcode: abandon the instruction without retiring it.
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      // IR is stable until the next FETCH, so the opcode still tells lw from sw.
      S_MEMADR: w_next = (bus.i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.i_mem_ready)     w_next = S_MEMWB;
        else if (w_wait_expired) w_next = S_FAULT;
      end
      S_MEMWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        if (bus.i_mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_wait_expired) begin
          w_next = S_FAULT;
        end
      end
      S_EXEC:  w_next = S_ALUWB;
      S_ALUWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_IEXEC: w_next = S_IWB;
      S_IWB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_FAULT: w_next = S_FAULT;  // only reset leaves FAULT
      default: w_next = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, wait counter and retired counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !bus.i_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_retire)
        r_retired <= r_retired + 1'b1;  // wraps naturally at 2^CNT_W
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. Strobes follow the state register, so an async reset
  // drops any pending memWrite in the same cycle. In FETCH, IR and PC load only
  // on the cycle the memory actually returns the instruction.
  // ---------------------------------------------------------------------------
  logic       w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite, w_irWrite;
  logic       w_memToReg, w_regDst, w_regWrite, w_aluSrcA, w_aluConI;
  logic [1:0] w_aluSrcB, w_aluOp, w_pcSrc;

  always_comb begin
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_memToReg    = 1'b0;
    w_regDst      = 1'b0;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = 2'b00;
    w_aluOp       = 2'b00;
    w_aluConI     = 1'b0;
    w_pcSrc       = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = 2'b01;            // PC + 4
        w_irWrite = bus.i_mem_ready;
        w_pcWrite = bus.i_mem_ready;
      end
      S_DECODE: begin
        w_aluSrcB = 2'b11;            // speculative branch target
      end
      S_MEMADR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
      end
      S_MEMWB: begin
        w_memToReg = 1'b1;
        w_regWrite = 1'b1;
      end
      S_MEMWR: begin
        w_iorD     = 1'b1;
        w_memWrite = 1'b1;            // held for the whole wait
      end
      S_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = 2'b10;
      end
      S_ALUWB: begin
        w_regDst   = 1'b1;
        w_regWrite = 1'b1;
      end
      S_IEXEC: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
        w_aluOp   = 2'b10;
        w_aluConI = 1'b1;
      end
      S_IWB: begin
        w_regWrite = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA     = 1'b1;
        w_aluOp       = 2'b01;        // A - B drives the zero flag
        w_pcSrc       = 2'b01;
        w_pcWriteCond = 1'b1;
      end
      S_JUMP: begin
        w_pcSrc   = 2'b10;
        w_pcWrite = 1'b1;
      end
      default: ;                      // FAULT and unused: everything off
    endcase
  end

  assign bus.o_pcWrite     = w_pcWrite;
  assign bus.o_pcWriteCond = w_pcWriteCond;
  assign bus.o_iorD        = w_iorD;
  assign bus.o_memRead     = w_memRead;
  assign bus.o_memWrite    = w_memWrite;
  assign bus.o_irWrite     = w_irWrite;
  assign bus.o_memToReg    = w_memToReg;
  assign bus.o_regDst      = w_regDst;
  assign bus.o_regWrite    = w_regWrite;
  assign bus.o_aluSrcA     = w_aluSrcA;
  assign bus.o_aluSrcB     = w_aluSrcB;
  assign bus.o_aluOp       = w_aluOp;
  assign bus.o_aluConI     = w_aluConI;
  assign bus.o_pcSrc       = w_pcSrc;
  assign bus.o_state       = r_state;
  assign bus.o_retired     = r_retired;
  assign bus.o_illegal     = w_illegal;
  assign bus.o_fault       = (r_state == S_FAULT);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus randomized
// instruction streams with random memory wait states, checked cycle by cycle
// against the control vector each micro-step must present.
module tb_mc_ctrl;

  localparam int MWM = 3;   // MEM_WAIT_MAX under test
  localparam int CW  = 4;   // small counter so wrap-around is reached

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CW)) bus();

  mc_ctrl #(.MEM_WAIT_MAX(MWM), .CNT_W(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned ret_model = 0;

  typedef enum int {
    P_FETCH, P_DECODE, P_DECODE_ILL, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
    P_EXEC, P_ALUWB, P_IEXEC, P_IWB, P_BRANCH, P_JUMP, P_FAULT
  } phase_t;

  logic [18:0] obs;
  assign obs = {bus.o_pcWrite, bus.o_pcWriteCond, bus.o_iorD, bus.o_memRead,
                bus.o_memWrite, bus.o_irWrite, bus.o_memToReg, bus.o_regDst,
                bus.o_regWrite, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_aluOp,
                bus.o_aluConI, bus.o_pcSrc, bus.o_illegal, bus.o_fault};

  // Expected control vector for each micro-step, straight from the step table.
  function automatic logic [18:0] exp_ctrl(phase_t p, logic rdy);
    logic pcW, pcWC, iorD, mR, mW, irW, m2r, rd, rw, sa, ci, ill, flt;
    logic [1:0] sb, op, ps;
    {pcW, pcWC, iorD, mR, mW, irW, m2r, rd, rw, sa, ci, ill, flt} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (p)
      P_FETCH:      begin mR = 1; sb = 2'b01; irW = rdy; pcW = rdy; end
      P_DECODE:     begin sb = 2'b11; end
      P_DECODE_ILL: begin sb = 2'b11; ill = 1; end
      P_MEMADR:     begin sa = 1; sb = 2'b10; end
      P_MEMRD:      begin mR = 1; iorD = 1; end
      P_MEMWB:      begin m2r = 1; rw = 1; end
      P_MEMWR:      begin iorD = 1; mW = 1; end
      P_EXEC:       begin sa = 1; op = 2'b10; end
      P_ALUWB:      begin rd = 1; rw = 1; end
      P_IEXEC:      begin sa = 1; sb = 2'b10; op = 2'b10; ci = 1; end
      P_IWB:        begin rw = 1; end
      P_BRANCH:     begin sa = 1; op = 2'b01; ps = 2'b01; pcWC = 1; end
      P_JUMP:       begin ps = 2'b10; pcW = 1; end
      P_FAULT:      begin flt = 1; end
      default: ;
    endcase
    return {pcW, pcWC, iorD, mR, mW, irW, m2r, rd, rw, sa, sb, op, ci, ps, ill, flt};
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001100, 6'b001101, 6'b001010};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock of a micro-step: drive at the falling edge, sample 1ns later.
  task automatic step(phase_t p, logic rdy);
    @(negedge clk);
    bus.i_mem_ready = rdy;
    bus.i_zero      = 1'($urandom);
    #1;
    check($sformatf("ctrl_%s", p.name()), 32'(obs), 32'(exp_ctrl(p, rdy)));
  endtask

  // Non-memory steps see random ready: it must not matter there.
  task automatic step_r(phase_t p);
    step(p, 1'($urandom_range(0, 1)));
  endtask

  task automatic mem_phase(phase_t p, int waits);
    repeat (waits) step(p, 1'b0);
    step(p, 1'b1);
  endtask

  task automatic check_retired(string tag);
    check(tag, 32'(bus.o_retired), ret_model % (32'd1 << CW));
  endtask

  // Full instruction from FETCH back to the next FETCH. fw<0 picks random waits.
  task automatic run_instr(logic [5:0] op, int fw);
    int w;
    bit retires;
    bus.i_opcode = op;
    retires = 1'b1;
    w = (fw < 0) ? int'($urandom_range(0, MWM)) : fw;
    mem_phase(P_FETCH, w);
    w = (fw < 0) ? int'($urandom_range(0, MWM)) : fw;
    case (op)
      6'b000000: begin step_r(P_DECODE); step_r(P_EXEC); step_r(P_ALUWB); end
      6'b100011: begin step_r(P_DECODE); step_r(P_MEMADR); mem_phase(P_MEMRD, w); step_r(P_MEMWB); end
      6'b101011: begin step_r(P_DECODE); step_r(P_MEMADR); mem_phase(P_MEMWR, w); end
      6'b000100: begin step_r(P_DECODE); step_r(P_BRANCH); end
      6'b000010: begin step_r(P_DECODE); step_r(P_JUMP); end
      6'b001000, 6'b001100, 6'b001101, 6'b001010:
                 begin step_r(P_DECODE); step_r(P_IEXEC); step_r(P_IWB); end
      default:   begin step_r(P_DECODE_ILL); retires = 1'b0; end
    endcase
    @(posedge clk);
    #1;
    if (retires) ret_model++;
    check_retired($sformatf("retired_op%b", op));
  endtask

  // Reset asserted asynchronously, released just after a rising edge so the
  // following FETCH cycle starts clean.
  task automatic do_reset();
    bus.i_mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    ret_model = 0;
    check("reset_retired", 32'(bus.o_retired), 32'd0);
    check("reset_ctrl", 32'(obs), 32'(exp_ctrl(P_FETCH, 1'b0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [5:0] legal_ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

  initial begin
    bus.i_opcode    = 6'b000000;
    bus.i_zero      = 1'b0;
    bus.i_mem_ready = 1'b0;
    #2;
    do_reset();

    // Directed: R-type, lw with two stalled reads, beq, j, illegal opcode.
    run_instr(6'b000000, 0);
    run_instr(6'b100011, 2);
    run_instr(6'b000100, 0);
    run_instr(6'b000010, 0);
    run_instr(6'b111111, 0);

    // Boundary: ready on the last tolerated cycle completes normally.
    run_instr(6'b101011, MWM);

    // Boundary: one not-ready cycle too many in FETCH faults; fault is sticky.
    repeat (MWM + 1) step(P_FETCH, 1'b0);
    repeat (4) step_r(P_FAULT);
    check("fault_retired", 32'(bus.o_retired), ret_model % (32'd1 << CW));
    do_reset();

    // Reset during a stalled sw: write strobe drops at once, count cleared.
    run_instr(6'b000000, 0);
    run_instr(6'b001101, 0);
    bus.i_opcode = 6'b101011;
    mem_phase(P_FETCH, 0);
    step_r(P_DECODE);
    step_r(P_MEMADR);
    step(P_MEMWR, 1'b0);
    step(P_MEMWR, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("rst_memWrite", 32'(bus.o_memWrite), 32'd0);
    check("rst_retired", 32'(bus.o_retired), 32'd0);
    check("rst_ctrl", 32'(obs), 32'(exp_ctrl(P_FETCH, 1'b0)));
    @(posedge clk);
    #1;
    rst = 1'b0;
    ret_model = 0;

    // Random instruction stream, long enough to wrap the retired counter.
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 5) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      run_instr(op, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle sequencer for the MIPS datapath: one shared memory port, an instruction register, and ALU reuse for PC+4 and the branch target.
- Decodes the 6-bit opcode latched in IR and steps a Moore FSM that drives every datapath select/enable, one micro-step per clock.
- Handles memory wait states through a ready handshake, with a bounded-wait fault.
- Reports retired-instruction count and illegal opcodes.

Parameters:
MEM_WAIT_MAX, 15, max consecutive not-ready cycles tolerated in a memory-access state before FAULT (>=1).
CNT_W, 32, width of retired-instruction counter.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_opcode  in  6  IR[31:26]
i_zero  in  1  ALU zero flag (unused internally; datapath ANDs with o_pcWriteCond)
i_mem_ready  in  1  memory completes access this cycle
o_pcWrite  out  1  unconditional PC load
o_pcWriteCond  out  1  PC load if zero
o_iorD  out  1  0=PC addresses memory, 1=ALUOut
o_memRead  out  1  memory read strobe
o_memWrite  out  1  memory write strobe
o_irWrite  out  1  IR load
o_memToReg  out  1  0=ALUOut, 1=MDR to regfile
o_regDst  out  1  0=rt, 1=rd
o_regWrite  out  1  regfile write enable
o_aluSrcA  out  1  0=PC, 1=A
o_aluSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
o_aluOp  out  2  00 add, 01 sub, 10 funct-decoded
o_aluConI  out  1  ALU control uses opcode instead of funct
o_pcSrc  out  2  00=ALU, 01=ALUOut, 10=jump target
o_state  out  4  current state encoding (debug)
o_retired  out  CNT_W  instructions completed, wraps
o_illegal  out  1  one-cycle pulse on unknown opcode
o_fault  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, i_rst=1): state=FETCH, wait counter=0, o_retired=0, o_fault=0, o_illegal=0. Other outputs take FETCH decode values.
- Outputs not listed per state are 0. Outputs are combinational from state; o_irWrite/o_pcWrite/o_memWrite are additionally qualified by i_mem_ready where stated.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00, irWrite=pcWrite=i_mem_ready. If ready -> DECODE, else stay.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011/101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001010 -> IEXEC
  - other -> FETCH with o_illegal=1 this cycle; no retire.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00 -> MEMRD if lw, MEMWR if sw.
- MEMRD: memRead=1, iorD=1; ready -> MEMWB.
- MEMWB: memToReg=1, regDst=0, regWrite=1 -> FETCH, retire.
- MEMWR: iorD=1, memWrite=1 (held while waiting); ready -> FETCH, retire.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10 -> ALUWB.
- ALUWB: regDst=1, regWrite=1 -> FETCH, retire.
- IEXEC: aluSrcA=1, aluSrcB=10, aluOp=10, aluConI=1 -> IWB.
- IWB: regDst=0, regWrite=1 -> FETCH, retire.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWriteCond=1 -> FETCH, retire.
- JUMP: pcSrc=10, pcWrite=1 -> FETCH, retire.
- FAULT: all strobes 0, o_fault=1; stays until reset.
- Retire: o_retired increments on the clock edge leaving a completing state; wraps 2^CNT_W-1 -> 0.
- Latency (ready always 1):
  - R-type, I-ALU, sw: 4 cycles
  - lw: 5 cycles
  - beq, j: 3 cycles
  - Each not-ready cycle adds one.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle in FETCH/MEMRD/MEMWR while i_mem_ready=0.
  - If counter==MEM_WAIT_MAX and ready=0 -> FAULT next edge, i.e. the (MEM_WAIT_MAX+1)th consecutive not-ready cycle faults.
  - ready=1 on that cycle completes normally.
- Reset mid-instruction: immediate return to FETCH; no partial retire; pending write strobes drop asynchronously.

Test Plan:
- Reset, ready=1, opcode 000000 -> states FETCH,DECODE,EXEC,ALUWB; regWrite=1, regDst=1 only in ALUWB; o_retired=1 after 4 clocks.
- lw (100011), ready low 2 cycles in MEMRD -> total 7 cycles; memToReg=1, regWrite=1 in MEMWB; o_retired +1.
- beq (000100) then j (000010) -> each 3 cycles; BRANCH shows pcWriteCond=1, pcSrc=01, aluOp=01; JUMP shows pcWrite=1, pcSrc=10; o_retired +2.
- Opcode 111111 -> o_illegal high exactly in DECODE cycle, next state FETCH, o_retired unchanged.
- MEM_WAIT_MAX=3, ready held 0 in FETCH -> FAULT after 4th low cycle; o_fault=1 and all strobes 0 until i_rst; ready=1 on 4th cycle instead -> DECODE, no fault.
- Assert i_rst during MEMWR with ready=0 -> memWrite drops same cycle, state=FETCH, o_retired=0.
